// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// FetchSequencer
//
// Purpose:
//   Micro-step sequencer for a small 8-bit fetch/execute machine. It owns the
//   micro-step counter, the 4-bit program counter and the 8-bit instruction
//   register. It also muxes PC or the IR operand onto the shared data bus.
//   The machine can free-run, be halted by the microcode controller and be
//   resumed. In builds with the optional feature it can also be single-stepped.
//
// Configuration:
//   SINGLE_STEP_EN  - when defined, a rising edge on Step while IDLE advances
//                     exactly one micro-step. When undefined, Step is ignored
//                     and no edge detector exists.
//
// Parameters:
//   STEP_LAST       - last micro-step index; Micro_Count wraps to 0 after it.
//
// Ports:
//   CLK                  in   sole clock, rising edge
//   Reset_N              in   asynchronous active-low reset
//   Run                  in   level, 1 = free-run micro-steps
//   Step                 in   single-step request (rising edge used)
//   Resume               in   level, leave HALTED
//   Halt_Signal          in   halt request from the microcode controller
//   Jump_Signal          in   load PC from IR operand
//   Program_Count_Enable in   increment PC
//   Program_Count_Out    in   drive PC onto the bus
//   Instruction_Reg_In   in   latch Data_Bus_In into IR
//   Instruction_Reg_Out  in   drive IR operand onto the bus
//   Data_Bus_In[7:0]     in   shared data bus value
//   Micro_Count[2:0]     out  current micro-step (registered)
//   Instruction_OpCode   out  IR[7:4]
//   Instruction_Operand  out  IR[3:0]
//   Program_Counter[3:0] out  current PC
//   Bus_Out[7:0]         out  zero-extended PC or operand, else 8'h00
//   Bus_Out_Valid        out  1 when Bus_Out carries a value
//   Halted               out  1 in HALTED state (registered)
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [2:0] STEP_LAST = 3'd4
) (
  input  logic       CLK,
  input  logic       Reset_N,
  input  logic       Run,
  input  logic       Step,
  input  logic       Resume,
  input  logic       Halt_Signal,
  input  logic       Jump_Signal,
  input  logic       Program_Count_Enable,
  input  logic       Program_Count_Out,
  input  logic       Instruction_Reg_In,
  input  logic       Instruction_Reg_Out,
  input  logic [7:0] Data_Bus_In,
  output logic [2:0] Micro_Count,
  output logic [3:0] Instruction_OpCode,
  output logic [3:0] Instruction_Operand,
  output logic [3:0] Program_Counter,
  output logic [7:0] Bus_Out,
  output logic       Bus_Out_Valid,
  output logic       Halted
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_nextState;

  logic [2:0] r_microCount;
  logic [3:0] r_pc;
  logic [7:0] r_ir;
  logic       r_halted;

  logic       w_advance;
  logic       w_clearCount;
  logic       w_stepEdge;
  logic [2:0] w_microNext;

  // Single-step edge detector. It exists only when the feature is built in.
  // It samples Step in every state. A Step held high through HALTED or RUN
  // therefore does not fire later when the machine returns to IDLE.
`ifdef SINGLE_STEP_EN
  logic r_stepPrev;

  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      r_stepPrev <= 1'b0;
    end else begin
      r_stepPrev <= Step;
    end
  end

  assign w_stepEdge = Step & ~r_stepPrev;
`else
  logic w_unusedStep;

  assign w_unusedStep = Step;
  assign w_stepEdge   = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Halt_Signal outranks Run in both IDLE and RUN.
  // Any illegal encoding falls back to IDLE.
  always_comb begin
    w_nextState = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (Halt_Signal)
          w_nextState = ST_HALTED;
        else if (Run)
          w_nextState = ST_RUN;
        else
          w_nextState = ST_IDLE;
      end
      ST_RUN: begin
        if (Halt_Signal)
          w_nextState = ST_HALTED;
        else if (!Run)
          w_nextState = ST_IDLE;
        else
          w_nextState = ST_RUN;
      end
      ST_HALTED: begin
        if (Resume)
          w_nextState = ST_IDLE;
        else
          w_nextState = ST_HALTED;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Output/control decode.
  // The IDLE->RUN transition cycle does not advance. Counting starts on the
  // first cycle actually spent in RUN, so the first visible step is 0.
  // When Run drops in RUN, the count is held for that cycle as well.
  always_comb begin
    w_advance    = 1'b0;
    w_clearCount = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!Halt_Signal)
          w_advance = w_stepEdge;
      end
      ST_RUN: begin
        if (!Halt_Signal && Run)
          w_advance = 1'b1;
      end
      ST_HALTED: begin
        if (Resume)
          w_clearCount = 1'b1;
      end
      default: w_clearCount = 1'b1;
    endcase
  end

  assign w_microNext = (r_microCount == STEP_LAST) ? 3'd0 : (r_microCount + 3'd1);

  // Micro-step counter. It moves only on an accepted advance and is cleared
  // when leaving HALTED.
  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      r_microCount <= 3'd0;
    end else if (w_clearCount) begin
      r_microCount <= 3'd0;
    end else if (w_advance) begin
      r_microCount <= w_microNext;
    end
  end

  // Program counter and instruction register share the advance qualifier.
  // Any control strobe seen outside an advancing cycle is dropped.
  // A jump uses the operand currently held in IR, not one being latched
  // in the same cycle.
  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      r_pc <= 4'h0;
      r_ir <= 8'h00;
    end else if (w_advance) begin
      if (Jump_Signal)
        r_pc <= r_ir[3:0];
      else if (Program_Count_Enable)
        r_pc <= r_pc + 4'h1;
      if (Instruction_Reg_In)
        r_ir <= Data_Bus_In;
    end
  end

  // Halted is a flop, so the output has no decode glitches.
  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      r_halted <= 1'b0;
    end else begin
      r_halted <= (w_nextState == ST_HALTED);
    end
  end

  // Bus driver. PC wins when both sources are requested.
  always_comb begin
    Bus_Out = 8'h00;
    if (Program_Count_Out)
      Bus_Out = {4'b0000, r_pc};
    else if (Instruction_Reg_Out)
      Bus_Out = {4'b0000, r_ir[3:0]};
  end

  assign Bus_Out_Valid       = Program_Count_Out | Instruction_Reg_Out;
  assign Micro_Count         = r_microCount;
  assign Program_Counter     = r_pc;
  assign Instruction_OpCode  = r_ir[7:4];
  assign Instruction_Operand = r_ir[3:0];
  assign Halted              = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// TbFetchSequencer
//
// Purpose:
//   Directed testbench for fetch_sequencer. Each expected value is worked out
//   by hand from the intended behaviour of the sequencer.
//   Inputs change and outputs are sampled 1 ns after each rising clock edge.
//   Step expectations depend on SINGLE_STEP_EN.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic       CLK;
  logic       Reset_N;
  logic       Run;
  logic       Step;
  logic       Resume;
  logic       Halt_Signal;
  logic       Jump_Signal;
  logic       Program_Count_Enable;
  logic       Program_Count_Out;
  logic       Instruction_Reg_In;
  logic       Instruction_Reg_Out;
  logic [7:0] Data_Bus_In;
  logic [2:0] Micro_Count;
  logic [3:0] Instruction_OpCode;
  logic [3:0] Instruction_Operand;
  logic [3:0] Program_Counter;
  logic [7:0] Bus_Out;
  logic       Bus_Out_Valid;
  logic       Halted;

  int totalCount = 0;
  int badCount   = 0;

  fetch_sequencer #(.STEP_LAST(3'd4)) dut (
    .CLK                  (CLK),
    .Reset_N              (Reset_N),
    .Run                  (Run),
    .Step                 (Step),
    .Resume               (Resume),
    .Halt_Signal          (Halt_Signal),
    .Jump_Signal          (Jump_Signal),
    .Program_Count_Enable (Program_Count_Enable),
    .Program_Count_Out    (Program_Count_Out),
    .Instruction_Reg_In   (Instruction_Reg_In),
    .Instruction_Reg_Out  (Instruction_Reg_Out),
    .Data_Bus_In          (Data_Bus_In),
    .Micro_Count          (Micro_Count),
    .Instruction_OpCode   (Instruction_OpCode),
    .Instruction_Operand  (Instruction_Operand),
    .Program_Counter      (Program_Counter),
    .Bus_Out              (Bus_Out),
    .Bus_Out_Valid        (Bus_Out_Valid),
    .Halted               (Halted)
  );

  // 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance a number of clock edges and settle 1 ns past the last one.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Count a comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, observed, expected);
    end
  endtask

  // Main directed sequence.
  initial begin
    logic [2:0] runSeq [12];
    logic [2:0] stepExp;
    logic [3:0] stepOpExp;

    runSeq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};

    Reset_N = 1'b0; Run = 1'b0; Step = 1'b0; Resume = 1'b0;
    Halt_Signal = 1'b0; Jump_Signal = 1'b0; Program_Count_Enable = 1'b0;
    Program_Count_Out = 1'b0; Instruction_Reg_In = 1'b0;
    Instruction_Reg_Out = 1'b0; Data_Bus_In = 8'h00;

    // Reset state.
    applyStimulus(2);
    checkOutput("rstMicro", {5'd0, Micro_Count}, 8'h00);
    checkOutput("rstPc", {4'd0, Program_Counter}, 8'h00);
    checkOutput("rstIr", {Instruction_OpCode, Instruction_Operand}, 8'h00);
    checkOutput("rstHalted", {7'd0, Halted}, 8'h00);
    checkOutput("rstBus", Bus_Out, 8'h00);
    checkOutput("rstBusValid", {7'd0, Bus_Out_Valid}, 8'h00);
    Reset_N = 1'b1;

    // Free-run: 0,1,2,3,4,0,... with the first cycle entering RUN.
    Run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("runSeq%0d", i), {5'd0, Micro_Count}, {5'd0, runSeq[i]});
    end

    // Dropping Run returns to IDLE and holds the count at 1.
    Run = 1'b0;
    applyStimulus(1);
    checkOutput("runDropHold", {5'd0, Micro_Count}, 8'h01);

    // An IR strobe in IDLE is ignored.
    Instruction_Reg_In = 1'b1; Data_Bus_In = 8'h5A;
    applyStimulus(1);
    checkOutput("irIgnoredIdle", {Instruction_OpCode, Instruction_Operand}, 8'h00);

    // IDLE->RUN cycle does not advance; the next cycle latches IR.
    Run = 1'b1;
    applyStimulus(1);
    checkOutput("enterRunNoAdv", {5'd0, Micro_Count}, 8'h01);
    applyStimulus(1);
    Instruction_Reg_In = 1'b0;
    checkOutput("irLoad", {Instruction_OpCode, Instruction_Operand}, 8'h5A);
    checkOutput("irLoadMicro", {5'd0, Micro_Count}, 8'h02);

    // Bus mux: operand alone, both (PC wins), neither.
    Instruction_Reg_Out = 1'b1;
    #1;
    checkOutput("busOperand", Bus_Out, 8'h0A);
    checkOutput("busOperandValid", {7'd0, Bus_Out_Valid}, 8'h01);
    Program_Count_Out = 1'b1;
    #1;
    checkOutput("busPcWins", Bus_Out, 8'h00);
    Instruction_Reg_Out = 1'b0;
    Program_Count_Out = 1'b0;
    #1;
    checkOutput("busIdleValid", {7'd0, Bus_Out_Valid}, 8'h00);

    // Jump beats increment: PC <- operand A.
    Jump_Signal = 1'b1; Program_Count_Enable = 1'b1;
    applyStimulus(1);
    Jump_Signal = 1'b0;
    checkOutput("jumpPriority", {4'd0, Program_Counter}, 8'h0A);

    // Increment A->F, then wrap F->0. Micro count ends at 4.
    applyStimulus(5);
    checkOutput("pcReachF", {4'd0, Program_Counter}, 8'h0F);
    Program_Count_Out = 1'b1;
    #1;
    checkOutput("busPcF", Bus_Out, 8'h0F);
    Program_Count_Out = 1'b0;
    applyStimulus(1);
    checkOutput("pcWrap", {4'd0, Program_Counter}, 8'h00);
    checkOutput("pcWrapMicro", {5'd0, Micro_Count}, 8'h04);

    // Bring micro count to 2, then halt while still strobing increment.
    applyStimulus(3);
    checkOutput("preHaltMicro", {5'd0, Micro_Count}, 8'h02);
    checkOutput("preHaltPc", {4'd0, Program_Counter}, 8'h03);
    Halt_Signal = 1'b1;
    applyStimulus(1);
    Halt_Signal = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("haltMicro%0d", i), {5'd0, Micro_Count}, 8'h02);
      checkOutput($sformatf("haltFlag%0d", i), {7'd0, Halted}, 8'h01);
      applyStimulus(1);
    end
    checkOutput("haltPcFrozen", {4'd0, Program_Counter}, 8'h03);

    // Resume: back to IDLE with the count cleared and PC/IR kept.
    Resume = 1'b1; Run = 1'b0; Program_Count_Enable = 1'b0;
    applyStimulus(1);
    Resume = 1'b0;
    checkOutput("resumeMicro", {5'd0, Micro_Count}, 8'h00);
    checkOutput("resumeHalted", {7'd0, Halted}, 8'h00);
    checkOutput("resumePc", {4'd0, Program_Counter}, 8'h03);
    checkOutput("resumeIr", {Instruction_OpCode, Instruction_Operand}, 8'h5A);

    // Run to PC=7: one entry cycle plus 4 increments from 3.
    Run = 1'b1; Program_Count_Enable = 1'b1;
    applyStimulus(5);
    Run = 1'b0; Program_Count_Enable = 1'b0;
    checkOutput("pcReach7", {4'd0, Program_Counter}, 8'h07);

    // Asynchronous reset pulse between edges.
    #2 Reset_N = 1'b0;
    #1;
    checkOutput("asyncRstPc", {4'd0, Program_Counter}, 8'h00);
    checkOutput("asyncRstMicro", {5'd0, Micro_Count}, 8'h00);
    checkOutput("asyncRstIr", {Instruction_OpCode, Instruction_Operand}, 8'h00);
    #1 Reset_N = 1'b1;

    // Step held high for 5 cycles in IDLE, with an IR load riding along.
`ifdef SINGLE_STEP_EN
    stepExp = 3'd1;
    stepOpExp = 4'h3;
`else
    stepExp = 3'd0;
    stepOpExp = 4'h0;
`endif
    Step = 1'b1; Instruction_Reg_In = 1'b1; Data_Bus_In = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("stepHeld%0d", i), {5'd0, Micro_Count}, {5'd0, stepExp});
    end
    checkOutput("stepIrOp", {4'd0, Instruction_OpCode}, {4'd0, stepOpExp});
    Step = 1'b0; Instruction_Reg_In = 1'b0;

    // Halt from IDLE, then resume.
    Halt_Signal = 1'b1;
    applyStimulus(1);
    Halt_Signal = 1'b0;
    checkOutput("idleHalt", {7'd0, Halted}, 8'h01);
    Resume = 1'b1;
    applyStimulus(1);
    Resume = 1'b0;
    checkOutput("idleHaltResume", {7'd0, Halted}, 8'h00);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
